// File: rtl/lane_block_engine.sv
// Falling-block engine for one piano lane. Each slot is its own instance
// holding a height and valid bit. The top level picks a spawn target, a
// hit target and a miss count, and registers the event pulses.

module lane_block_slot #(
  parameter int H_W     = 10,
  parameter int SPAWN_H = 120,
  parameter int FLOOR_H = 720
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           spawn,
  input  logic           retire,
  input  logic           move,
  input  logic [H_W:0]   step,
  output logic [H_W-1:0] h,
  output logic           vld,
  output logic           floor_hit
);
  localparam logic [H_W:0]   FLOOR_V = (H_W+1)'(FLOOR_H);
  localparam logic [H_W-1:0] SPAWN_V = H_W'(SPAWN_H);

  // One extra bit so a height near the top of the range cannot wrap below the floor.
  logic [H_W:0] nh;
  assign nh        = {1'b0, h} + step;
  assign floor_hit = vld & move & ~retire & (nh >= FLOOR_V);

  // Slot state. Spawn only targets a free slot, so it never collides with
  // retire or motion. A slot leaving via the floor keeps its last height.
  always_ff @(posedge clk) begin
    if (clr) begin
      h   <= '0;
      vld <= 1'b0;
    end else if (spawn) begin
      h   <= SPAWN_V;
      vld <= 1'b1;
    end else if (retire | floor_hit) begin
      vld <= 1'b0;
    end else if (vld & move) begin
      h <= nh[H_W-1:0];
    end
  end
endmodule

module lane_block_engine #(
  parameter int                   NUM_SLOTS = 4,
  parameter int                   H_W       = 10,
  parameter int                   BEAT_W    = 7,
  parameter logic [2**BEAT_W-1:0] SPAWN_MAP = '0,
  parameter int                   SPAWN_H   = 120,
  parameter int                   FLOOR_H   = 720,
  parameter int                   HIT_LO    = 600,
  parameter int                   HIT_HI    = 680
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     restart,
  input  logic                     stop_or_endgame,
  input  logic [1:0]               level,
  input  logic [BEAT_W-1:0]        beat_cnt,
  input  logic                     hit,
  output logic [NUM_SLOTS*H_W-1:0] block_h,
  output logic [NUM_SLOTS-1:0]     block_valid,
  output logic                     hit_ok,
  output logic                     hit_bad,
  output logic                     miss,
  output logic [7:0]               miss_total,
  output logic                     spawn_drop
);
  localparam logic [H_W-1:0] HIT_LO_V = H_W'(HIT_LO);
  localparam logic [H_W-1:0] HIT_HI_V = H_W'(HIT_HI);

  logic [NUM_SLOTS-1:0][H_W-1:0] h_q;
  logic [NUM_SLOTS-1:0]          vld_q, spawn_oh, hit_sel, hit_oh, floor_v;
  logic [BEAT_W-1:0]             pre_beat;
  logic                          clr, act, spawn_req, found, cand, hit_en, move_en;
  logic [H_W-1:0]                best_h;
  logic [H_W:0]                  step;
  logic [3:0]                    miss_cnt;
  logic [8:0]                    miss_sum;

  assign clr         = rst | restart;
  assign act         = ~stop_or_endgame;
  assign spawn_req   = (beat_cnt > pre_beat) & SPAWN_MAP[beat_cnt] & act;
  assign hit_en      = hit & act;
  assign move_en     = tick & act;
  assign step        = (H_W+1)'(level) + (H_W+1)'(1);
  assign hit_oh      = hit_en ? hit_sel : '0;
  assign block_h     = h_q;
  assign block_valid = vld_q;

  // Spawn target: lowest slot free at the start of the cycle.
  always_comb begin
    spawn_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!vld_q[i] && !found) begin
        spawn_oh[i] = spawn_req;
        found       = 1'b1;
      end
    end
  end

  // Hit target: highest in-window block; strict compare keeps the lowest index on a tie.
  always_comb begin
    hit_sel = '0;
    cand    = 1'b0;
    best_h  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (vld_q[i] && h_q[i] >= HIT_LO_V && h_q[i] <= HIT_HI_V &&
          (!cand || h_q[i] > best_h)) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        best_h     = h_q[i];
        cand       = 1'b1;
      end
    end
  end

  // Count the slots reaching the floor this cycle.
  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) miss_cnt = miss_cnt + 4'(floor_v[i]);
    miss_sum = {1'b0, miss_total} + 9'(miss_cnt);
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    lane_block_slot #(.H_W(H_W), .SPAWN_H(SPAWN_H), .FLOOR_H(FLOOR_H)) u_slot (
      .clk       (clk),
      .clr       (clr),
      .spawn     (spawn_oh[i]),
      .retire    (hit_oh[i]),
      .move      (move_en),
      .step      (step),
      .h         (h_q[i]),
      .vld       (vld_q[i]),
      .floor_hit (floor_v[i])
    );
  end

  // Beat history, event pulses and the saturating miss counter.
  // pre_beat follows beat_cnt even while frozen, so beats passed then are lost.
  always_ff @(posedge clk) begin
    if (clr) begin
      pre_beat   <= '0;
      hit_ok     <= 1'b0;
      hit_bad    <= 1'b0;
      miss       <= 1'b0;
      spawn_drop <= 1'b0;
      miss_total <= '0;
    end else begin
      pre_beat   <= beat_cnt;
      hit_ok     <= hit_en & cand;
      hit_bad    <= hit_en & ~cand;
      miss       <= |floor_v;
      spawn_drop <= spawn_req & ~found;
      miss_total <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end
  end
endmodule
